har_frame_loader: RTL

Streaming front end for the combinational `Har` BNN classifier. It accepts one B-bit feature per handshake beat, shifts N beats into a packed N*B-bit frame, and drives that frame onto `Har`'s `inp`. After a fixed settle window it captures `Har`'s `klass` and offers it downstream on a valid/ready result port. It sits directly upstream of `Har` and wraps its output into a registered, back-pressurable result.

---
 rtl/har_pkg.sv | 21 ++
 rtl/har_frame_shift.sv | 49 ++++
 rtl/har_frame_loader.sv | 92 +++++++++
 3 files changed

// File: rtl/har_pkg.sv
// rtl/har_pkg.sv - shared defaults and state type for the Har frame loader
package har_pkg;

  localparam int HAR_N = 12;
  localparam int HAR_B = 4;
  localparam int HAR_C = 6;

  // Index width that stays legal for a single class.
  function automatic int har_kw(input int c);
    return (c > 1) ? $clog2(c) : 1;
  endfunction

  localparam int HAR_KW = har_kw(HAR_C);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } har_ld_state_t;

endpackage

// File: rtl/har_frame_shift.sv
// rtl/har_frame_shift.sv - N*B feature shift register with beat counter and framing detect
module har_frame_shift
  import har_pkg::*;
#(
  parameter int N = HAR_N,
  parameter int B = HAR_B
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           beat_i,
  input  logic           last_i,
  input  logic [B-1:0]   feat_i,
  output logic [N*B-1:0] frame_o,
  output logic           done_o,
  output logic           err_o
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [N*B-1:0] frame_q, frame_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           at_end;

  assign at_end  = (cnt_q == CW'(N - 1));
  assign done_o  = beat_i & at_end & last_i;
  // Early last or missing last: the beat still shifts in but the frame is dropped.
  assign err_o   = beat_i & (at_end ^ last_i);
  assign frame_o = frame_q;

  always_comb begin
    frame_d = frame_q;
    cnt_d   = cnt_q;
    if (beat_i) begin
      frame_d = {frame_q[N*B-B-1:0], feat_i};
      cnt_d   = (at_end || last_i) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
      cnt_q   <= '0;
    end else begin
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/har_frame_loader.sv
// rtl/har_frame_loader.sv - streams features into a frame for Har and registers its class
module har_frame_loader
  import har_pkg::*;
#(
  parameter int N   = HAR_N,
  parameter int B   = HAR_B,
  parameter int C   = HAR_C,
  parameter int KW  = har_kw(C),
  parameter int LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [B-1:0]   feat_in,
  input  logic           feat_valid,
  input  logic           feat_last,
  output logic           feat_ready,
  output logic [N*B-1:0] inp,
  input  logic [KW-1:0]  klass_in,
  output logic [KW-1:0]  res_klass,
  output logic           res_valid,
  input  logic           res_ready,
  output logic           frame_err
);

  localparam int SW = (LAT > 1) ? $clog2(LAT) : 1;

  har_ld_state_t state_q;
  logic [SW-1:0] settle_q;
  logic [KW-1:0] res_klass_q;
  logic          res_valid_q;
  logic          frame_err_q;
  logic          beat, shift_done, shift_err;

  assign feat_ready = (state_q == FILL);
  assign beat       = feat_valid & feat_ready;

  har_frame_shift #(
    .N(N),
    .B(B)
  ) u_shift (
    .clk    (clk),
    .rst    (rst),
    .beat_i (beat),
    .last_i (feat_last),
    .feat_i (feat_in),
    .frame_o(inp),
    .done_o (shift_done),
    .err_o  (shift_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      settle_q    <= '0;
      res_klass_q <= '0;
      res_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= shift_err;
      case (state_q)
        FILL: begin
          if (shift_done) begin
            settle_q <= '0;
            state_q  <= SETTLE;
          end
        end
        SETTLE: begin
          // Har is combinational; inp is frozen here so klass_in settles within LAT cycles.
          if (settle_q == SW'(LAT - 1)) begin
            res_klass_q <= klass_in;
            res_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign res_klass = res_klass_q;
  assign res_valid = res_valid_q;
  assign frame_err = frame_err_q;

endmodule
